// File: rtl/fb_access_arb_pkg.sv
// Shared constants and FSM encoding for the framebuffer access arbiter.
// Pulled in by the arbiter top and its round-robin picker.
package fb_access_arb_pkg;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NREQ    = 3;

    localparam int unsigned REQ_PAINT  = 0;
    localparam int unsigned REQ_CURSOR = 1;
    localparam int unsigned REQ_PALETA = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOwned = 2'd1,
        StClear = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
// Produces a one-hot pick, or zero when nothing is requested.
module rr_pick #(
    parameter int unsigned NREQ  = fb_access_arb_pkg::NREQ,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  pick
);

    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        // Search order starts one past the previous owner.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == (32'(last) + k) % NREQ)) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fb_access_arb.sv
// Framebuffer access arbiter: round-robin burst ownership for pixel writers plus
// a full-screen clear engine. All state advances on the falling clock edge.
module fb_access_arb #(
    parameter int unsigned COORD_W = fb_access_arb_pkg::COORD_W,
    parameter int unsigned DATA_W  = fb_access_arb_pkg::DATA_W,
    parameter int unsigned NREQ    = fb_access_arb_pkg::NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr,
    input  logic [NREQ*COORD_W-1:0] x,
    input  logic [NREQ*COORD_W-1:0] y,
    input  logic [NREQ*DATA_W-1:0]  wdata,
    output logic [NREQ-1:0]         gnt,
    input  logic                    clr_start,
    output logic                    clr_busy,
    output logic                    clr_done,
    output logic                    fb_we,
    output logic [2*COORD_W-1:0]    fb_addr,
    output logic [DATA_W-1:0]       fb_wdata
);

    import fb_access_arb_pkg::*;

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned ADDR_W = 2 * COORD_W;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;

    logic [NREQ-1:0]    pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               wr_ok;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [DATA_W-1:0]  sel_wdata;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick[j]) pick_idx = IDX_W'(j);
        end
    end

    // Only the granted requester's strobe and pixel fields reach the framebuffer.
    always_comb begin
        wr_ok     = |(gnt_q & wr);
        sel_x     = '0;
        sel_y     = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_x     = x[i*COORD_W +: COORD_W];
                sel_y     = y[i*COORD_W +: COORD_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;

        if (clr_start && (state_q != StClear)) pend_d = 1'b1;

        if (wr_ok) begin
            we_d    = 1'b1;
            addr_d  = {sel_y, sel_x};
            wdata_d = sel_wdata;
        end

        unique case (state_q)
            StIdle: begin
                // A clear requested this cycle already beats any requester.
                if (pend_q || clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (|req) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    state_d = StOwned;
                end
            end
            StOwned: begin
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            StClear: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = StIdle;
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            gnt_q   <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign clr_busy = pend_q;
    assign clr_done = done_q;
    assign fb_we    = we_q;
    assign fb_addr  = addr_q;
    assign fb_wdata = wdata_q;

endmodule

// File: tb/tb_fb_access_arb.sv
// Bench for fb_access_arb: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of arbitration and clearing.
module tb_fb_access_arb;

    localparam int CW = 6;
    localparam int DW = 8;
    localparam int N  = 3;
    localparam int AW = 2 * CW;
    localparam int NPIX = 1 << AW;

    localparam int M_IDLE  = 0;
    localparam int M_OWNED = 1;
    localparam int M_CLEAR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, wr, gnt;
    logic [N*CW-1:0] x, y;
    logic [N*DW-1:0] wdata;
    logic            clr_start, clr_busy, clr_done, fb_we;
    logic [AW-1:0]   fb_addr;
    logic [DW-1:0]   fb_wdata;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_mode, m_owner, m_last, m_caddr;
    logic [N-1:0] m_gnt;
    logic         m_we, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;

    logic [N-1:0] order [$];
    int           hold, nwr, ndone;
    logic [31:0]  r;

    fb_access_arb #(
        .COORD_W (CW),
        .DATA_W  (DW),
        .NREQ    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .x         (x),
        .y         (y),
        .wdata     (wdata),
        .gnt       (gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Next model state from the inputs present at the coming falling edge.
    task automatic model_edge();
        int   old_mode;
        logic old_pend, nwe, ndn, found;
        if (rst === 1'b0) begin
            m_mode = M_IDLE; m_owner = 0; m_last = N - 1; m_caddr = 0;
            m_gnt = '0; m_we = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_addr = '0; m_wd = '0;
            return;
        end
        old_mode = m_mode;
        old_pend = m_busy;
        nwe = 1'b0;
        ndn = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_gnt[i] && wr[i]) begin
                nwe    = 1'b1;
                m_addr = {y[i*CW +: CW], x[i*CW +: CW]};
                m_wd   = wdata[i*DW +: DW];
            end
        end
        if (clr_start === 1'b1 && old_mode != M_CLEAR) m_busy = 1'b1;
        case (old_mode)
            M_IDLE: begin
                if (old_pend || clr_start === 1'b1) begin
                    m_mode  = M_CLEAR;
                    m_caddr = 0;
                end else if (req != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && req[(m_last + k) % N]) begin
                            m_owner = (m_last + k) % N;
                            found   = 1'b1;
                        end
                    end
                    m_gnt = '0;
                    m_gnt[m_owner] = 1'b1;
                    m_mode = M_OWNED;
                end
            end
            M_OWNED: begin
                if (!req[m_owner]) begin
                    m_gnt  = '0;
                    m_last = m_owner;
                    m_mode = M_IDLE;
                end
            end
            default: begin
                nwe    = 1'b1;
                m_addr = AW'(m_caddr);
                m_wd   = '0;
                if (m_caddr == NPIX - 1) begin
                    m_mode = M_IDLE;
                    m_busy = 1'b0;
                    ndn    = 1'b1;
                end
                m_caddr = (m_caddr + 1) % NPIX;
            end
        endcase
        m_we   = nwe;
        m_done = ndn;
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("fb_we", 32'(fb_we), 32'(m_we));
        chk("fb_addr", 32'(fb_addr), 32'(m_addr));
        chk("fb_wdata", 32'(fb_wdata), 32'(m_wd));
        chk("clr_busy", 32'(clr_busy), 32'(m_busy));
        chk("clr_done", 32'(clr_done), 32'(m_done));
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic set_pix(input int i, input int xx, input int yy, input int dd);
        x[i*CW +: CW]     = CW'(xx);
        y[i*CW +: CW]     = CW'(yy);
        wdata[i*DW +: DW] = DW'(dd);
    endtask

    task automatic wait_gnt(input string tag, input logic [N-1:0] want, input int bound);
        for (int c = 0; c < bound && gnt !== want; c++) step();
        chk(tag, 32'(gnt), 32'(want));
    endtask

    task automatic run_clear(input int bound, output int nw, output int nd);
        nw = 0;
        nd = 0;
        for (int c = 0; c < bound && nd == 0; c++) begin
            step();
            if (fb_we === 1'b1) begin
                chk("clr_addr", 32'(fb_addr), 32'(nw));
                nw++;
            end
            if (clr_done === 1'b1) nd++;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (clr_done === 1'b1) nd++;
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; wr = '0; x = '0; y = '0; wdata = '0; clr_start = 1'b0;
        m_mode = M_IDLE; m_owner = 0; m_last = N - 1; m_caddr = 0;
        m_gnt = '0; m_we = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_addr = '0; m_wd = '0;

        // Reset state
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        rst = 1'b1;
        step();

        // All three request, each holds two grant cycles: order 0,1,2
        req  = 3'b111;
        hold = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (gnt != '0) begin
                if (hold == 0) order.push_back(gnt);
                hold++;
                if (hold == 2) begin
                    req  = req & ~gnt;
                    hold = 0;
                end
            end
        end
        chk("order_n", 32'(order.size()), 3);
        for (int i = 0; i < order.size() && i < 3; i++) chk("order", 32'(order[i]), 32'(1 << i));

        // Cursor owns; paint waits; cursor write lands one cycle later
        req = 3'b010;
        wait_gnt("cursor_gnt", 3'b010, 5);
        req = 3'b011;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("no_preempt", 32'(gnt), 32'(3'b010));
        end
        set_pix(1, 5, 7, 8'hA3);
        wr = 3'b010;
        step();
        chk("cur_we", 32'(fb_we), 1);
        chk("cur_addr", 32'(fb_addr), 32'h1C5);
        chk("cur_data", 32'(fb_wdata), 32'hA3);
        wr = 3'b100;
        set_pix(2, 9, 9, 8'h55);
        step();
        chk("ungranted_wr", 32'(fb_we), 0);
        wr  = '0;
        req = 3'b001;
        step();
        chk("idle_gap", 32'(gnt), 0);
        step();
        chk("paint_after", 32'(gnt), 32'(3'b001));

        // Clear requested while paint owns: waits for release, then 4096 writes
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("busy_rise", 32'(clr_busy), 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("clr_waits", 32'(gnt), 32'(3'b001));
        end
        req = '0;
        run_clear(NPIX + 100, nwr, ndone);
        chk("clr_count", 32'(nwr), 32'(NPIX));
        chk("clr_done_n", 32'(ndone), 1);
        chk("busy_fall", 32'(clr_busy), 0);

        // Reset at clear address 100 aborts the clear for good
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int c = 0; c < 200 && !(fb_we === 1'b1 && fb_addr === AW'(100)); c++) step();
        chk("reach_100", 32'(fb_addr), 100);
        rst = 1'b0;
        step();
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_we", 32'(fb_we), 0);
        chk("abort_addr", 32'(fb_addr), 0);
        chk("abort_data", 32'(fb_wdata), 0);
        chk("abort_busy", 32'(clr_busy), 0);
        chk("abort_done", 32'(clr_done), 0);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) step();
        req = 3'b001;
        step();
        step();
        chk("post_rst_gnt", 32'(gnt), 32'(3'b001));
        req = '0;
        step();
        step();

        // Same-cycle clr_start and cursor request: clear first
        req       = 3'b010;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("tie_no_gnt", 32'(gnt), 0);
        run_clear(NPIX + 100, nwr, ndone);
        chk("tie_clr_n", 32'(nwr), 32'(NPIX));
        chk("tie_done_n", 32'(ndone), 1);
        wait_gnt("tie_cursor", 3'b010, 4);
        req = '0;
        step();
        step();

        // Random traffic, occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            r = $urandom; wr = r[N-1:0];
            r = $urandom; x = r[N*CW-1:0];
            r = $urandom; y = r[N*CW-1:0];
            r = $urandom; wdata = r[N*DW-1:0];
            clr_start = ($urandom_range(0, 999) == 0);
            rst = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_access_arb.md
FB_ACCESS_ARB -- requirements
Module: fb_access_arb

Interface
REQ-001 Parameter COORD_W, default 6, pixel coordinate width (64x64 framebuffer).
REQ-002 Parameter DATA_W, default 8, pixel data width.
REQ-003 Parameter NREQ, default 3, requesters (0 = paint, 1 = cursor, 2 = palette cursor).
REQ-004 Ports; one clock, reset is synchronous and active-low:
  - clk  in  1  single clock; all state changes on negedge clk, matching the paint controller.
  - rst  in  1  synchronous active-low reset.
  - req  in  NREQ  per-requester access request, level, held for the whole burst.
  - wr  in  NREQ  per-requester pixel write strobe, one pixel per cycle.
  - x  in  NREQ*COORD_W  packed per-requester x coordinate.
  - y  in  NREQ*COORD_W  packed per-requester y coordinate.
  - wdata  in  NREQ*DATA_W  packed per-requester pixel data.
  - gnt  out  NREQ  one-hot grant; at most one bit set.
  - clr_start  in  1  single-cycle request to clear the framebuffer.
  - clr_busy  out  1  high while a clear is pending or running.
  - clr_done  out  1  one-cycle pulse after the last clear write.
  - fb_we  out  1  framebuffer write enable.
  - fb_addr  out  2*COORD_W  framebuffer address {y,x}.
  - fb_wdata  out  DATA_W  framebuffer write data.

Function
REQ-005 FSM states: IDLE, OWNED, CLEAR.
REQ-006 IDLE, no clear pending, any req set: select owner by round-robin starting at (last+1) mod NREQ, set gnt, go OWNED next cycle.
REQ-007 OWNED: gnt held while req[owner] stays high; no preemption, including by the paint requester.
REQ-008 OWNED, req[owner] low: clear gnt, set last=owner, return to IDLE; minimum one IDLE cycle between grants.
REQ-009 Writes: wr[i] counts only when gnt[i] is high; wr without gnt is ignored and never reaches fb_we.
REQ-010 Write latency: a counted wr in cycle N produces fb_we=1 with registered fb_addr={y[i],x[i]} and fb_wdata=wdata[i] in cycle N+1.
REQ-011 fb_we is 0 in every cycle without an accepted write; fb_addr and fb_wdata hold their last values.
REQ-012 clr_start sets a pending flag; clr_busy rises the cycle after clr_start.
REQ-013 clr_start during OWNED waits for release; CLEAR has priority over all requesters in IDLE.
REQ-014 CLEAR: a 2*COORD_W-bit counter runs 0 to 2^(2*COORD_W)-1 and writes one pixel of 0 per cycle, 4096 cycles at the default.
REQ-015 CLEAR end: when the counter wraps from all-ones, pulse clr_done once, drop clr_busy and the pending flag, and return to IDLE; last is unchanged.
REQ-016 No gnt is asserted during CLEAR; requests wait.
REQ-017 clr_start during CLEAR is ignored; no restart and no second clr_done.
REQ-018 Simultaneous clr_start and req in IDLE: CLEAR wins.

Reset
REQ-019 rst low at a clock edge: state=IDLE, gnt=0, fb_we=0, fb_addr=0, fb_wdata=0, clr_busy=0, clr_done=0, pending=0, clear counter=0, last=NREQ-1 so requester 0 wins first.
REQ-020 Reset mid-burst or mid-clear aborts immediately; the clear does not resume and clr_done does not pulse.

Structure
REQ-021 Shared package holds COORD_W, DATA_W, NREQ, the requester index constants (REQ_PAINT=0, REQ_CURSOR=1, REQ_PALETA=2) and the FSM state encodings.
REQ-022 Round-robin selection lives in one sub-module, rr_pick: inputs req and last, output one-hot pick, purely combinational; all registers stay in fb_access_arb.

Verification
REQ-023 req=3'b111 from reset, each held 2 cycles then dropped -> grants in order 0, 1, 2, each separated by one IDLE cycle with gnt=0.
REQ-024 Cursor owns; paint raises req -> paint not granted until cursor drops req; cursor wr with x=5, y=7, data=8'hA3 -> next cycle fb_we=1, fb_addr=12'h1C5, fb_wdata=8'hA3.
REQ-025 wr[2]=1 while gnt[2]=0 -> fb_we stays 0.
REQ-026 clr_start while paint owns -> clear starts after release; exactly 4096 consecutive fb_we with data 0 at addresses 0..4095; one clr_done; no gnt in between.
REQ-027 rst low at clear address 100 -> all outputs reset next cycle; no clr_done; a subsequent req=3'b001 is granted normally.
REQ-028 clr_start and req=3'b010 in the same IDLE cycle -> CLEAR first; cursor granted after clr_done.
